// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg : shared states and constants for the display self-test sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package display_pkg;

  typedef enum logic [2:0] {
    PASS  = 3'd0,
    WALK  = 3'd1,
    FILL  = 3'd2,
    RGB   = 3'd3,
    ALLON = 3'd4
  } state_t;

  localparam int WALK_STEPS  = 64;
  localparam int FILL_STEPS  = 16;
  localparam int RGB_STEPS   = 8;
  localparam int ALLON_STEPS = 1;

  localparam logic [7:0] SEG_ALL = 8'hFF;

  // Index of the final step of a test state; the state advances on its tick.
  function automatic logic [5:0] last_step(input state_t s);
    case (s)
      WALK:    return 6'(WALK_STEPS - 1);
      FILL:    return 6'(FILL_STEPS - 1);
      RGB:     return 6'(RGB_STEPS - 1);
      ALLON:   return 6'(ALLON_STEPS - 1);
      default: return 6'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pb_debounce.sv
// ============================================================================
// pb_debounce : 2-FF synchronizer, level debouncer and rising-edge event pulse
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pb_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic sync,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          meta;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= 1'b0;
      sync    <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      meta    <= pb;
      sync    <= meta;
      level_q <= level;
      // Any sample agreeing with the current level restarts the count.
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

`default_nettype wire

// File: rtl/display_selftest.sv
// ============================================================================
// display_selftest : pushbutton pass-through with a PB[19]-triggered output test
// Revision         : 1.0
// ============================================================================
`default_nettype none

module display_selftest
  import display_pkg::*;
#(
  parameter int TICK_DIV = 25,
  parameter int DEBOUNCE = 3
) (
  input  logic        HZ100,
  input  logic        RESET_N,
  input  logic [19:0] PB,
  output logic [7:0]  RIGHT,
  output logic [7:0]  LEFT,
  output logic        RED,
  output logic        GREEN,
  output logic        BLUE,
  output logic [7:0]  SS0,
  output logic [7:0]  SS1,
  output logic [7:0]  SS2,
  output logic [7:0]  SS3,
  output logic [7:0]  SS4,
  output logic [7:0]  SS5,
  output logic [7:0]  SS6,
  output logic [7:0]  SS7,
  output logic        BUSY
);

  localparam int PW = $clog2(TICK_DIV);

  logic [18:0]      pb_meta;
  logic [18:0]      pb_sync;
  logic             sync19;
  logic             event_p;
  logic [19:0]      s;
  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    presc;
  logic [5:0]       step;
  logic             tick;
  logic [7:0][7:0]  ss_w;
  logic [15:0]      leds_w;
  logic [2:0]       rgb_w;

  pb_debounce #(.DEBOUNCE(DEBOUNCE)) u_start (
    .clk   (HZ100),
    .rst_n (RESET_N),
    .pb    (PB[19]),
    .sync  (sync19),
    .rise  (event_p)
  );

  always_ff @(posedge HZ100 or negedge RESET_N) begin
    if (!RESET_N) begin
      pb_meta <= '0;
      pb_sync <= '0;
    end else begin
      pb_meta <= PB[18:0];
      pb_sync <= pb_meta;
    end
  end

  assign s    = {sync19, pb_sync};
  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge HZ100 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= PASS;
    end else begin
      state <= state_nxt;
    end
  end

  // A start/abort event overrides any same-cycle step-driven advance.
  always_comb begin
    state_nxt = state;
    if (event_p) begin
      state_nxt = (state == PASS) ? WALK : PASS;
    end else if (state != PASS && tick && step == last_step(state)) begin
      case (state)
        WALK:    state_nxt = FILL;
        FILL:    state_nxt = RGB;
        RGB:     state_nxt = ALLON;
        default: state_nxt = PASS;
      endcase
    end
  end

  always_ff @(posedge HZ100 or negedge RESET_N) begin
    if (!RESET_N) begin
      presc <= '0;
      step  <= '0;
    end else if (state_nxt != state || state == PASS) begin
      presc <= '0;
      step  <= '0;
    end else if (tick) begin
      presc <= '0;
      step  <= step + 6'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    ss_w   = '0;
    leds_w = '0;
    rgb_w  = '0;
    case (state)
      PASS: begin
        leds_w  = s[15:0];
        rgb_w   = s[18:16];
        ss_w[0] = s[7:0];
        ss_w[1] = s[8:1];
        ss_w[2] = s[9:2];
        ss_w[3] = s[10:3];
        ss_w[4] = s[16:9];
        ss_w[5] = s[17:10];
        ss_w[6] = s[18:11];
        ss_w[7] = s[19:12];
      end
      WALK: begin
        ss_w[step[5:3]] = 8'd1 << step[2:0];
        leds_w          = 16'd1 << step[3:0];
      end
      FILL: begin
        // 17-bit intermediate so the last step yields all ones after truncation.
        leds_w = 16'((17'd1 << ({1'b0, step[3:0]} + 5'd1)) - 17'd1);
      end
      RGB: begin
        rgb_w = step[2:0];
      end
      ALLON: begin
        ss_w   = {8{SEG_ALL}};
        leds_w = '1;
        rgb_w  = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge HZ100 or negedge RESET_N) begin
    if (!RESET_N) begin
      RIGHT <= '0;
      LEFT  <= '0;
      RED   <= 1'b0;
      GREEN <= 1'b0;
      BLUE  <= 1'b0;
      SS0   <= '0;
      SS1   <= '0;
      SS2   <= '0;
      SS3   <= '0;
      SS4   <= '0;
      SS5   <= '0;
      SS6   <= '0;
      SS7   <= '0;
      BUSY  <= 1'b0;
    end else begin
      RIGHT <= leds_w[7:0];
      LEFT  <= leds_w[15:8];
      {RED, GREEN, BLUE} <= rgb_w;
      SS0   <= ss_w[0];
      SS1   <= ss_w[1];
      SS2   <= ss_w[2];
      SS3   <= ss_w[3];
      SS4   <= ss_w[4];
      SS5   <= ss_w[5];
      SS6   <= ss_w[6];
      SS7   <= ss_w[7];
      BUSY  <= (state != PASS);
    end
  end

endmodule

`default_nettype wire
